// File: rtl/nibble_serial_adder_if.sv
// Handshake and data bundle for the nibble-serial adder.
// slave = the adder, master = whoever feeds it and consumes results.
interface nibble_serial_adder_if #(
   parameter int NIBBLES = 4
);
   localparam int W = 4 * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;
   logic         out_valid;
   logic         out_ready;
   logic [W:0]   out_sum;
   logic         out_ovf;
   logic         busy;

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, busy
   );

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, busy
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial adder: one 4-bit lookahead nibble per cycle, result is
// {carry-out, W-bit sum} plus signed overflow.
//
// state | meaning
// IDLE  | waiting for an operand set, in_ready high
// RUN   | adding nibble idx_q each cycle
// DONE  | result presented, held until out_ready
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input logic                 clk,
   input logic                 rst,
   nibble_serial_adder_if.slave bus
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, b_q;
   logic          carry_q;
   logic [IW-1:0] idx_q;
   logic [W:0]    result_q;
   logic          ovf_q;

   logic          accept, step, last;
   logic          in_ready_c, out_valid_c, busy_c;
   logic [IW+1:0] bit_base;
   logic [3:0]    a_nib, b_nib, g, p, s_nib;
   logic [4:0]    c;

   assign last     = (idx_q == IW'(NIBBLES - 1));
   assign bit_base = {idx_q, 2'b00};

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next state and handshake outputs
   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      busy_c      = 1'b0;
      accept      = 1'b0;
      step        = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy_c = 1'b1;
            step   = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            busy_c      = 1'b1;
            out_valid_c = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // flattened 4-bit carry lookahead on the current nibble
   always_comb begin
      a_nib = a_q[bit_base +: 4];
      b_nib = b_q[bit_base +: 4];
      g     = a_nib & b_nib;
      p     = a_nib ^ b_nib;
      c[0]  = carry_q;
      c[1]  = g[0] | (p[0] & c[0]);
      c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c[0]);
      c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
      s_nib = p ^ c[3:0];
   end

   // operand capture and per-nibble accumulation
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else if (accept) begin
         a_q      <= bus.in_a;
         b_q      <= bus.in_b;
         carry_q  <= bus.in_cin;
         idx_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else if (step) begin
         result_q[bit_base +: 4] <= s_nib;
         carry_q                 <= c[4];
         idx_q                   <= idx_q + 1'b1;
         if (last) begin
            // c[3] is the carry into bit W-1 on the top nibble
            result_q[W] <= c[4];
            ovf_q       <= c[3] ^ c[4];
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.busy      = busy_c;
   assign bus.out_sum   = result_q;
   assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder with NIBBLES = 4: directed vectors with
// literal expectations plus a transaction-level reference checked every cycle.
module tb_nibble_serial_adder;
   localparam int N = 4;
   localparam int W = 4 * N;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   bit   chk_en = 1'b0;

   nibble_serial_adder_if #(.NIBBLES(N)) bus ();
   nibble_serial_adder #(.NIBBLES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // reference: 0 idle, 1 running, 2 done
   int         m_mode = 0;
   int         m_cnt  = 0;
   logic [W:0] m_sum  = '0;
   logic       m_ovf  = 1'b0;
   logic [W:0] m_pend_sum;
   logic       m_pend_ovf;
   bit         b2b = 1'b0;
   int         last_acc = -1;

   always @(posedge clk) begin
      longint sa, sb, st;
      cyc++;
      if (rst) begin
         m_mode = 0; m_cnt = 0; m_sum = '0; m_ovf = 1'b0;
      end else begin
         case (m_mode)
            0: if (bus.in_valid) begin
               m_pend_sum = {1'b0, bus.in_a} + {1'b0, bus.in_b} + (W+1)'(bus.in_cin);
               sa = longint'($signed(bus.in_a));
               sb = longint'($signed(bus.in_b));
               st = sa + sb + longint'(bus.in_cin);
               m_pend_ovf = (st > (64'sd1 <<< (W-1)) - 1) || (st < -(64'sd1 <<< (W-1)));
               m_mode = 1; m_cnt = 0;
               if (b2b && last_acc >= 0) check("accept_spacing", cyc - last_acc, N + 2);
               last_acc = cyc;
            end
            1: begin
               m_cnt++;
               if (m_cnt == N) begin
                  m_mode = 2; m_sum = m_pend_sum; m_ovf = m_pend_ovf;
               end
            end
            default: if (bus.out_ready) m_mode = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready",  bus.in_ready,  (m_mode == 0));
         check("out_valid", bus.out_valid, (m_mode == 2));
         check("busy",      bus.busy,      (m_mode != 0));
         if (m_mode != 1) begin
            check("out_sum", bus.out_sum, m_sum);
            check("out_ovf", bus.out_ovf, m_ovf);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // start one operation, wait for the result, check latency and value
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W:0] exp_sum, input logic exp_ovf, input string tag);
      int n;
      n = 0;
      while (!bus.in_ready && n < 30) begin tick(); n++; end
      if (!bus.in_ready) check({tag, "_ready_timeout"}, 0, 1);
      bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_valid = 1'b1;
      tick();
      if (!b2b) bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 30) begin tick(); n++; end
      check({tag, "_latency"}, n, N);
      check({tag, "_sum"}, bus.out_sum, exp_sum);
      check({tag, "_ovf"}, bus.out_ovf, exp_ovf);
   endtask

   task automatic release_result();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
      bus.out_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_in_ready",  bus.in_ready,  1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy",      bus.busy,      0);
      check("rst_out_sum",   bus.out_sum,   0);
      check("rst_out_ovf",   bus.out_ovf,   0);

      do_op(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0, "carry_out"); release_result();
      do_op(16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1, "pos_ovf");   release_result();
      do_op(16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1, "neg_ovf");   release_result();
      do_op(16'h1234, 16'h4321, 1'b1, 17'h05556, 1'b0, "cin");

      // hold in DONE while new operands are offered
      for (int i = 0; i < 5; i++) begin
         bus.in_a = 16'hAAAA + 16'(i); bus.in_b = 16'h5555; bus.in_valid = i[0];
         tick();
         check("hold_sum", bus.out_sum, 17'h05556);
         check("hold_in_ready", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
      release_result();
      check("idle_retain", bus.out_sum, 17'h05556);
      check("idle_in_ready", bus.in_ready, 1);

      // reset mid-operation after two nibbles
      bus.in_a = 16'hFFFF; bus.in_b = 16'hFFFF; bus.in_cin = 1'b1; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
      tick();
      rst = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
      check("midrst_in_ready",  bus.in_ready,  1);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_out_sum",   bus.out_sum,   0);
      do_op(16'h00FF, 16'h0001, 1'b0, 17'h00100, 1'b0, "after_rst"); release_result();

      // back-to-back with in_valid and out_ready held high
      b2b = 1'b1;
      last_acc = -1;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
         do_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 17'(rc),
               ($signed(ra) + $signed(rb) + $signed({16'h0, rc})) > 32767 ||
               ($signed(ra) + $signed(rb) + $signed({16'h0, rc})) < -32768 ? 1'b1 : 1'b0,
               "b2b");
      end
      bus.in_valid = 1'b0;
      tick(); tick();
      bus.out_ready = 1'b0;
      b2b = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter NIBBLES, default 4: operand width W = 4*NIBBLES bits, processed one 4-bit nibble per cycle; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand set valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 in_a  input  W  unsigned/two's-complement operand A.
REQ-007 in_b  input  W  operand B.
REQ-008 in_cin  input  1  carry-in to nibble 0.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_sum  output  W+1  {carry-out, W-bit sum}.
REQ-012 out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE; busy = 1 in RUN and DONE.
REQ-015 Accept on rising edge with in_valid & in_ready: register in_a, in_b, carry register <= in_cin, nibble index <= 0, result register <= 0, go RUN.
REQ-016 In RUN, each cycle computes nibble k = index: {c, s} = A[4k+3:4k] + B[4k+3:4k] + carry, using 4-bit lookahead generate/propagate (g = a&b, p = a^b, c[i+1] = g[i] | p[i]&c[i] flattened), no inter-bit ripple inside the nibble.
REQ-017 On each RUN edge: result[4k+3:4k] <= s, carry <= c, index <= index+1.
REQ-018 On the edge processing nibble NIBBLES-1: result[W] <= c, out_ovf register <= carry into bit W-1 XOR c, go DONE.
REQ-019 Latency: out_valid rises exactly NIBBLES rising edges after the accepting edge.
REQ-020 Arithmetic is modulo 2^(W+1); out_sum equals in_a + in_b + in_cin exactly for all inputs.
REQ-021 In DONE, out_sum and out_ovf held stable while out_ready = 0, for any number of cycles.
REQ-022 On rising edge with out_valid & out_ready: go IDLE; out_valid deasserts next cycle; in_ready asserts next cycle (no same-cycle accept in DONE).
REQ-023 Back-to-back throughput with in_valid and out_ready held high: one result per NIBBLES+2 cycles.
REQ-024 in_valid, in_a, in_b, in_cin ignored outside IDLE; changes during RUN/DONE do not affect the result.
REQ-025 out_sum and out_ovf retain the last result in IDLE until the next accept clears the result register.
REQ-026 NIBBLES = 1: RUN lasts one cycle; REQ-019 still holds.

Reset
REQ-027 rst high on a rising edge: state <= IDLE, index <= 0, carry <= 0, result and ovf <= 0, regardless of state; any in-flight operation discarded.
REQ-028 Post-reset output values: in_ready = 1, out_valid = 0, busy = 0, out_sum = 0, out_ovf = 0.
REQ-029 rst takes priority over in_valid and out_ready on the same edge.

Verification (NIBBLES = 4)
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> out_sum=0x10000, out_ovf=0, out_valid on 4th edge after accept.
REQ-031 a=0x7FFF, b=0x0001, cin=0 -> out_sum=0x08000, out_ovf=1; a=0x8000, b=0x8000 -> out_sum=0x10000, out_ovf=1.
REQ-032 a=0x1234, b=0x4321, cin=1 -> out_sum=0x05556, out_ovf=0.
REQ-033 out_ready low 5 cycles in DONE while in_valid pulses with new operands -> out_sum held, in_ready=0, new operands not captured.
REQ-034 rst asserted in RUN after 2 nibbles -> next cycle in_ready=1, out_valid=0, out_sum=0; following operation a=0x00FF, b=0x0001 -> 0x00100.
REQ-035 in_valid and out_ready held high, 3 random operand sets -> results correct, accepts spaced exactly 6 cycles apart.
